lsu_dmem_if: RTL and testbench

- Load/store unit in the MEM stage, directly downstream of the instruction decoder.
- Consumes the decoder's memory controls (mem_read, mem_write, d_size, d_unsigned) together with the EX-stage address and store data.
- Drives a req/gnt/rvalid data-memory port, aligns byte lanes, and sign- or zero-extends load data.
- Stalls the pipeline until each access completes; flags misaligned or illegal accesses without touching memory.

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_align.sv | 32 +++
 rtl/lsu_dmem_if.sv | 154 +++++++++++++++
 tb/tb_lsu_dmem_if.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared types and helpers for the MEM-stage load/store unit.
//   lsu_state_t  : access FSM states
//   SIZE_B/H/W   : d_size lane masks for byte, half and word accesses
//   load_extend  : extracts the addressed byte/half from a memory word and
//                  sign- or zero-extends it; words pass through unchanged
// -----------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_R,
        RESP
    } lsu_state_t;

    localparam logic [3:0] SIZE_B = 4'b0001;
    localparam logic [3:0] SIZE_H = 4'b0011;
    localparam logic [3:0] SIZE_W = 4'b1111;

    function automatic logic [31:0] load_extend(
        input logic [31:0] word,
        input logic [1:0]  off,
        input logic [3:0]  size,
        input logic        is_unsigned
    );
        logic [31:0] shifted;
        shifted = word >> {off, 3'b000};
        case (size)
            SIZE_B:  return is_unsigned ? {24'h0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            SIZE_H:  return is_unsigned ? {16'h0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational byte-lane steering for the load/store unit.
//   off         in  2   byte offset within the word (addr[1:0])
//   size        in  4   lane mask (SIZE_B / SIZE_H / SIZE_W)
//   wdata       in  32  right-justified store data
//   is_unsigned in  1   zero-extend loads when 1
//   rdata       in  32  raw word returned by memory
//   be          out 4   byte enables, lane mask shifted to the offset
//   wdata_sh    out 32  store data shifted onto its lanes
//   load_data   out 32  extracted and extended load result
// -----------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [3:0]  size,
    input  logic [31:0] wdata,
    input  logic        is_unsigned,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic [31:0] load_data
);

    always_comb begin
        be        = size << off;
        wdata_sh  = wdata << {off, 3'b000};
        load_data = load_extend(rdata, off, size, is_unsigned);
    end

endmodule

// File: rtl/lsu_dmem_if.sv
// -----------------------------------------------------------------------------
// lsu_dmem_if
// MEM-stage load/store unit driving a req/gnt/rvalid data-memory port.
// Stalls the pipeline until each access completes; misaligned or illegal
// accesses are rejected with err_o without any memory traffic.
//   clk_i, rst_i          clock, synchronous active-high reset
//   valid_i               MEM-stage instruction valid
//   mem_read_i/_write_i   decoder memory controls
//   d_size_i, d_unsigned_i lane mask and load extension mode
//   addr_i, wdata_i       effective byte address, right-justified store data
//   stall_o               hold IF/ID/EX/MEM pipeline registers
//   done_o, err_o         one-cycle completion / rejection pulses
//   rdata_o               extended load result (holds last load value)
//   dmem_*                data-memory request port
// -----------------------------------------------------------------------------
module lsu_dmem_if
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [3:0]        d_size_i,
    input  logic              d_unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              stall_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [DATA_W-1:0] dmem_rdata_i
);

    lsu_state_t        state, state_nxt;

    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        size_q;
    logic [DATA_W-1:0] wdata_q;
    logic              unsigned_q;
    logic              we_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;

    logic              access;
    logic              misaligned;
    logic              illegal;
    logic              bad_access;

    logic [3:0]        be_sh;
    logic [DATA_W-1:0] wdata_sh;
    logic [DATA_W-1:0] load_data;

    assign access     = valid_i & (mem_read_i | mem_write_i);
    assign misaligned = ((d_size_i == SIZE_H) & addr_i[0]) |
                        ((d_size_i == SIZE_W) & (addr_i[1:0] != 2'b00));
    assign illegal    = ((d_size_i != SIZE_B) & (d_size_i != SIZE_H) &
                         (d_size_i != SIZE_W)) |
                        (mem_read_i & mem_write_i);
    assign bad_access = misaligned | illegal;

    // Lane steering works only from latched fields so the request stays
    // stable while gnt is outstanding, whatever the pipeline does meanwhile.
    lsu_align u_align (
        .off         (addr_q[1:0]),
        .size        (size_q),
        .wdata       (wdata_q),
        .is_unsigned (unsigned_q),
        .rdata       (dmem_rdata_i),
        .be          (be_sh),
        .wdata_sh    (wdata_sh),
        .load_data   (load_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: next state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (access) state_nxt = bad_access ? RESP : REQ;
            end
            REQ: begin
                if (dmem_gnt_i) state_nxt = we_q ? RESP : WAIT_R;
            end
            WAIT_R: begin
                if (dmem_rvalid_i) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the datapath registers are reset as well as the FSM, because
    // rdata_o is visible directly and must read 0 straight out of reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q     <= '0;
            size_q     <= '0;
            wdata_q    <= '0;
            unsigned_q <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            if (state == IDLE && access) begin
                addr_q     <= addr_i;
                size_q     <= d_size_i;
                wdata_q    <= wdata_i;
                unsigned_q <= d_unsigned_i;
                we_q       <= mem_write_i;
                err_q      <= bad_access;
            end
            // Only a completing read updates the result; stores leave it alone.
            if (state == WAIT_R && dmem_rvalid_i) begin
                rdata_q <= load_data;
            end
        end
    end

    // Request fields are forced to zero outside REQ so the port is quiet
    // whenever no request is outstanding, including right after reset.
    always_comb begin
        dmem_req_o   = (state == REQ);
        dmem_we_o    = dmem_req_o & we_q;
        dmem_addr_o  = dmem_req_o ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
        dmem_be_o    = dmem_req_o ? be_sh : 4'b0000;
        dmem_wdata_o = dmem_req_o ? wdata_sh : '0;
    end

    // Stall drops in RESP so the pipeline advances exactly once per access.
    assign stall_o = (state == REQ) | (state == WAIT_R) | ((state == IDLE) & access);
    assign done_o  = (state == RESP);
    assign err_o   = (state == RESP) & err_q;
    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_lsu_dmem_if.sv
// -----------------------------------------------------------------------------
// tb_lsu_dmem_if
// Directed bench for lsu_dmem_if: stores, loads with extension, delayed
// grant, rejected accesses and reset in the middle of a load.
// -----------------------------------------------------------------------------
module tb_lsu_dmem_if;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i, mem_read_i, mem_write_i, d_unsigned_i;
    logic [3:0]  d_size_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o, done_o, err_o;
    logic [31:0] rdata_o;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    lsu_dmem_if #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .valid_i       (valid_i),
        .mem_read_i    (mem_read_i),
        .mem_write_i   (mem_write_i),
        .d_size_i      (d_size_i),
        .d_unsigned_i  (d_unsigned_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .stall_o       (stall_o),
        .done_o        (done_o),
        .rdata_o       (rdata_o),
        .err_o         (err_o),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        valid_i       = 1'b0;
        mem_read_i    = 1'b0;
        mem_write_i   = 1'b0;
        d_size_i      = 4'b0000;
        d_unsigned_i  = 1'b0;
        addr_i        = '0;
        wdata_i       = '0;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = '0;
    endtask

    // Present an access in IDLE (T0) and let inputs settle.
    task automatic present(input logic rd, input logic wr, input logic [3:0] size,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wd);
        valid_i      = 1'b1;
        mem_read_i   = rd;
        mem_write_i  = wr;
        d_size_i     = size;
        d_unsigned_i = uns;
        addr_i       = addr;
        wdata_i      = wd;
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " stall"}, {31'b0, stall_o}, 32'd0);
        check({tag, " done"},  {31'b0, done_o},  32'd0);
        check({tag, " err"},   {31'b0, err_o},   32'd0);
        check({tag, " req"},   {31'b0, dmem_req_o}, 32'd0);
        check({tag, " we"},    {31'b0, dmem_we_o},  32'd0);
        check({tag, " addr"},  dmem_addr_o, 32'd0);
        check({tag, " be"},    {28'b0, dmem_be_o}, 32'd0);
        check({tag, " wdata"}, dmem_wdata_o, 32'd0);
    endtask

    // Store with immediate grant: done at T2.
    task automatic do_store(input string tag, input logic [3:0] size, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        present(1'b0, 1'b1, size, 1'b0, addr, wd);
        check({tag, " T0 stall"}, {31'b0, stall_o}, 32'd1);
        check({tag, " T0 req"},   {31'b0, dmem_req_o}, 32'd0);
        tick();
        idle_inputs();
        dmem_gnt_i = 1'b1;
        #1;
        check({tag, " T1 req"},   {31'b0, dmem_req_o}, 32'd1);
        check({tag, " T1 we"},    {31'b0, dmem_we_o},  32'd1);
        check({tag, " T1 addr"},  dmem_addr_o, exp_addr);
        check({tag, " T1 be"},    {28'b0, dmem_be_o}, {28'b0, exp_be});
        check({tag, " T1 wdata"}, dmem_wdata_o, exp_wdata);
        check({tag, " T1 stall"}, {31'b0, stall_o}, 32'd1);
        tick();
        dmem_gnt_i = 1'b0;
        #1;
        check({tag, " T2 done"},  {31'b0, done_o},  32'd1);
        check({tag, " T2 err"},   {31'b0, err_o},   32'd0);
        check({tag, " T2 stall"}, {31'b0, stall_o}, 32'd0);
        check({tag, " T2 req"},   {31'b0, dmem_req_o}, 32'd0);
        tick();
        check({tag, " T3 done"},  {31'b0, done_o},  32'd0);
    endtask

    // Load with immediate grant and rvalid one cycle later: done at T3.
    task automatic do_load(input string tag, input logic [3:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] mem_word,
                           input logic [31:0] exp_rdata);
        present(1'b1, 1'b0, size, uns, addr, 32'h0);
        check({tag, " T0 stall"}, {31'b0, stall_o}, 32'd1);
        tick();
        idle_inputs();
        dmem_gnt_i = 1'b1;
        #1;
        check({tag, " T1 req"},  {31'b0, dmem_req_o}, 32'd1);
        check({tag, " T1 we"},   {31'b0, dmem_we_o},  32'd0);
        check({tag, " T1 addr"}, dmem_addr_o, {addr[31:2], 2'b00});
        tick();
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = mem_word;
        #1;
        check({tag, " T2 req"},   {31'b0, dmem_req_o}, 32'd0);
        check({tag, " T2 stall"}, {31'b0, stall_o}, 32'd1);
        check({tag, " T2 done"},  {31'b0, done_o},  32'd0);
        tick();
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'h0;
        #1;
        check({tag, " T3 done"},  {31'b0, done_o},  32'd1);
        check({tag, " T3 stall"}, {31'b0, stall_o}, 32'd0);
        check({tag, " T3 rdata"}, rdata_o, exp_rdata);
        tick();
        check({tag, " T4 done"},  {31'b0, done_o},  32'd0);
    endtask

    // Rejected access: done+err at T1, no memory request at any point.
    task automatic do_reject(input string tag, input logic rd, input logic wr,
                             input logic [3:0] size, input logic [31:0] addr,
                             input logic [31:0] exp_rdata);
        present(rd, wr, size, 1'b0, addr, 32'h1234_5678);
        check({tag, " T0 stall"}, {31'b0, stall_o}, 32'd1);
        check({tag, " T0 req"},   {31'b0, dmem_req_o}, 32'd0);
        tick();
        idle_inputs();
        #1;
        check({tag, " T1 done"},  {31'b0, done_o},  32'd1);
        check({tag, " T1 err"},   {31'b0, err_o},   32'd1);
        check({tag, " T1 req"},   {31'b0, dmem_req_o}, 32'd0);
        check({tag, " T1 stall"}, {31'b0, stall_o}, 32'd0);
        tick();
        check_quiet({tag, " T2"});
        check({tag, " T2 rdata"}, rdata_o, exp_rdata);
    endtask

    initial begin
        idle_inputs();
        rst_i = 1'b1;
        tick();
        tick();
        check_quiet("reset");
        check("reset rdata", rdata_o, 32'h0);
        rst_i = 1'b0;
        tick();

        // Stray rvalid in IDLE must not disturb anything.
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hFFFF_FFFF;
        tick();
        idle_inputs();
        #1;
        check_quiet("idle rvalid");
        check("idle rvalid rdata", rdata_o, 32'h0);

        do_store("SW", 4'b1111, 32'h0000_0104, 32'hDEAD_BEEF,
                 32'h0000_0104, 4'b1111, 32'hDEAD_BEEF);
        do_store("SB", 4'b0001, 32'h0000_0103, 32'h0000_00A5,
                 32'h0000_0100, 4'b1000, 32'hA500_0000);
        do_store("SH", 4'b0011, 32'h0000_0102, 32'h0000_BEEF,
                 32'h0000_0100, 4'b1100, 32'hBEEF_0000);

        do_load("LB",  4'b0001, 1'b0, 32'h0000_0202, 32'h12F3_4567, 32'hFFFF_FFF3);
        do_load("LBU", 4'b0001, 1'b1, 32'h0000_0202, 32'h12F3_4567, 32'h0000_00F3);
        do_load("LHU", 4'b0011, 1'b1, 32'h0000_0202, 32'h12F3_4567, 32'h0000_12F3);
        do_load("LH",  4'b0011, 1'b0, 32'h0000_0200, 32'h0000_8001, 32'hFFFF_8001);
        do_load("LB0", 4'b0001, 1'b0, 32'h0000_0201, 32'h0000_7F00, 32'h0000_007F);

        // A store leaves the last load result in place.
        do_store("SB2", 4'b0001, 32'h0000_0100, 32'h0000_0011,
                 32'h0000_0100, 4'b0001, 32'h0000_0011);
        check("rdata held after store", rdata_o, 32'h0000_007F);

        // LW with grant delayed 3 cycles and rvalid 2 cycles after grant.
        present(1'b1, 1'b0, 4'b1111, 1'b0, 32'h0000_0300, 32'h0);
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            // A stray rvalid while still waiting for grant is ignored.
            dmem_rvalid_i = (i == 1);
            dmem_rdata_i  = 32'hBAD0_BAD0;
            #1;
            check("LW wait req",   {31'b0, dmem_req_o}, 32'd1);
            check("LW wait addr",  dmem_addr_o, 32'h0000_0300);
            check("LW wait be",    {28'b0, dmem_be_o}, 32'h0000_000F);
            check("LW wait done",  {31'b0, done_o}, 32'd0);
            check("LW wait stall", {31'b0, stall_o}, 32'd1);
            tick();
        end
        dmem_rvalid_i = 1'b0;
        dmem_gnt_i    = 1'b1;
        #1;
        check("LW gnt req",  {31'b0, dmem_req_o}, 32'd1);
        check("LW gnt addr", dmem_addr_o, 32'h0000_0300);
        tick();
        dmem_gnt_i = 1'b0;
        #1;
        check("LW wr1 req",  {31'b0, dmem_req_o}, 32'd0);
        check("LW wr1 done", {31'b0, done_o}, 32'd0);
        tick();
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hCAFE_F00D;
        #1;
        check("LW wr2 done", {31'b0, done_o}, 32'd0);
        tick();
        idle_inputs();
        #1;
        check("LW resp done",  {31'b0, done_o}, 32'd1);
        check("LW resp rdata", rdata_o, 32'hCAFE_F00D);
        tick();
        check("LW after done", {31'b0, done_o}, 32'd0);

        // Rejected accesses.
        do_reject("LH misaligned", 1'b1, 1'b0, 4'b0011, 32'h0000_0101, 32'hCAFE_F00D);
        do_reject("LW misaligned", 1'b1, 1'b0, 4'b1111, 32'h0000_0102, 32'hCAFE_F00D);
        do_reject("RW combo",      1'b1, 1'b1, 4'b1111, 32'h0000_0400, 32'hCAFE_F00D);
        do_reject("bad size",      1'b0, 1'b1, 4'b0111, 32'h0000_0400, 32'hCAFE_F00D);

        // Reset in WAIT_R; the later rvalid must be ignored.
        present(1'b1, 1'b0, 4'b1111, 1'b0, 32'h0000_0500, 32'h0);
        tick();
        idle_inputs();
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        rst_i      = 1'b1;
        #1;
        check("rst WAIT_R stall", {31'b0, stall_o}, 32'd1);
        tick();
        rst_i         = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h5555_AAAA;
        #1;
        check_quiet("rst after");
        check("rst after rdata", rdata_o, 32'h0);
        tick();
        idle_inputs();
        #1;
        check_quiet("rst late rvalid");
        check("rst late rdata", rdata_o, 32'h0);
        tick();
        check("rst settled done", {31'b0, done_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
